// File: rtl/store_pkg.sv
// Shared constants and the drain FSM state type for the store-drain path.
package store_pkg;
  localparam int SQ_DEPTH  = 16;
  localparam int IDX_W     = 4;
  localparam int CNT_W     = 5;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int MAX_RETRY = 3;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RELEASE,
    ERR
  } drain_state_t;
endpackage

// File: rtl/store_commit_cnt.sv
// Counts ROB-committed stores and reports how many are committed but not yet drained.
module store_commit_cnt
  import store_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             st_commit,
  input  logic [CNT_W-1:0] drain_num,
  output logic [CNT_W-1:0] commit_pend,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(SQ_DEPTH);

  logic [CNT_W-1:0] committed_num_reg;

  assign commit_pend = committed_num_reg - drain_num;
  // A commit that would exceed the store-queue depth is dropped and flagged.
  assign overflow    = st_commit && (commit_pend == FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      committed_num_reg <= '0;
    end else if (st_commit && !overflow) begin
      committed_num_reg <= committed_num_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/store_drain_ctrl.sv
// Drains executed-and-committed stores, oldest first, from the store-queue head
// into the D-cache write port, retrying failed writes a bounded number of times.
module store_drain_ctrl
  import store_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  store_exe_num,
  input  logic              st_commit,
  output logic [IDX_W-1:0]  sq_rd_idx,
  input  logic [ADDR_W-1:0] sq_rd_addr,
  input  logic [DATA_W-1:0] sq_rd_data,
  input  logic [BE_W-1:0]   sq_rd_be,
  output logic              dc_req,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [DATA_W-1:0] dc_wdata,
  output logic [BE_W-1:0]   dc_be,
  input  logic              dc_gnt,
  input  logic              dc_done,
  input  logic              dc_err,
  output logic              sq_release,
  output logic [CNT_W-1:0]  drain_num,
  output logic [CNT_W-1:0]  commit_pend,
  output logic              drain_busy,
  output logic              drain_err
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  drain_state_t       state_reg, state_next;
  logic [CNT_W-1:0]   drain_num_reg;
  logic [RETRY_W-1:0] retry_cnt_reg, retry_cnt_next;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  data_reg;
  logic [BE_W-1:0]    be_reg;
  logic               drain_err_reg;
  logic               overflow;
  logic               eligible;
  logic               load_payload;
  logic               drain_inc;
  logic [CNT_W-1:0]   exe_pend;

  store_commit_cnt u_commit_cnt (
    .clk         (clk),
    .reset       (reset),
    .st_commit   (st_commit),
    .drain_num   (drain_num_reg),
    .commit_pend (commit_pend),
    .overflow    (overflow)
  );

  // Modular differences keep eligibility correct across counter wrap.
  assign exe_pend = store_exe_num - drain_num_reg;
  assign eligible = (commit_pend != '0) && (exe_pend != '0);

  always_comb begin
    state_next     = state_reg;
    retry_cnt_next = retry_cnt_reg;
    load_payload   = 1'b0;
    drain_inc      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (eligible) begin
          load_payload = 1'b1;
          state_next   = REQ;
        end
      end
      REQ: begin
        if (dc_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (dc_done) begin
          if (!dc_err) begin
            state_next = RELEASE;
          end else if (retry_cnt_reg == RETRY_LIMIT) begin
            state_next = ERR;
          end else begin
            retry_cnt_next = retry_cnt_reg + RETRY_W'(1);
            state_next     = REQ;
          end
        end
      end
      RELEASE: begin
        drain_inc      = 1'b1;
        retry_cnt_next = '0;
        state_next     = IDLE;
      end
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      drain_num_reg <= '0;
      retry_cnt_reg <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      be_reg        <= '0;
      drain_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      retry_cnt_reg <= retry_cnt_next;
      if (drain_inc) drain_num_reg <= drain_num_reg + CNT_W'(1);
      if (load_payload) begin
        addr_reg <= sq_rd_addr;
        data_reg <= sq_rd_data;
        be_reg   <= sq_rd_be;
      end
      drain_err_reg <= drain_err_reg | overflow | (state_next == ERR);
    end
  end

  // Decoding from the async-reset state register drops dc_req the moment reset asserts.
  assign dc_req     = (state_reg == REQ);
  assign sq_release = (state_reg == RELEASE);
  assign drain_busy = (state_reg != IDLE);
  assign drain_err  = drain_err_reg;
  assign drain_num  = drain_num_reg;
  assign sq_rd_idx  = drain_num_reg[IDX_W-1:0];
  assign dc_addr    = addr_reg;
  assign dc_wdata   = data_reg;
  assign dc_be      = be_reg;

endmodule
